ptp_bus_arb: RTL and testbench
==============================

Name: ptp_bus_arb

Overview:
- Two-master arbiter/sequencer for the 32-bit bus2ip register interface of the PTP NIC (interrupt controller at 0x300, RX buffer at 0x1000, TX buffer at 0x2000).
- Shares the single slave port between m0 (host CPU bridge) and m1 (PTP firmware/descriptor sequencer).
- Issues one-cycle rd/wr chip-enable pulses, waits a fixed read latency, then returns data with a one-cycle ack to the winning master.
- Round-robin fairness when both masters request.

Parameters:
- RD_LAT, 2, cycles from s_rd_ce_o high to s_rdata_i valid; legal range 1..15.

Ports:
- bus2ip_clk  input  1  bus clock; all logic is on the rising edge.
- bus2ip_rst_n  input  1  asynchronous, active-low reset.
- m0_req_i  input  1  m0 request; held high until m0_ack_o.
- m0_we_i  input  1  m0 1=write, 0=read; stable while req is high.
- m0_addr_i  input  32  m0 byte address.
- m0_wdata_i  input  32  m0 write data.
- m0_ack_o  output  1  one-cycle completion pulse to m0.
- m0_rdata_o  output  32  m0 read data, valid with ack.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o: same as m0, for master 1.
- s_addr_o  output  32  slave bus2ip_addr.
- s_data_o  output  32  slave bus2ip_data.
- s_rd_ce_o  output  1  slave read strobe, active high.
- s_wr_ce_o  output  1  slave write strobe, active high.
- s_rdata_i  input  32  slave ip2bus_data.
- busy_o  output  1  high whenever state is not IDLE.
- grant_o  output  1  index of the master owning the current or last transaction.

Behaviour:
- Reset values: all outputs 0, state=IDLE, last_grant=1 (so m0 wins the first tie), wait counter=0. Reset asserted mid-transaction aborts it: no ack is issued and both ce strobes drop immediately.
- States:
  - IDLE: if any req, choose the winner, latch addr/wdata/we into s_addr_o/s_data_o/we register, set grant_o, go to ISSUE.
  - ISSUE: exactly one cycle with s_rd_ce_o or s_wr_ce_o high. Write goes to ACK. Read loads counter=RD_LAT-1 and goes to WAIT (RD_LAT=1 goes directly to CAPT).
  - WAIT: decrement each cycle; when the counter is 0, go to CAPT.
  - CAPT: register s_rdata_i into the winner's rdata_o, go to ACK.
  - ACK: winner's ack_o high for one cycle; reqs ignored; update last_grant=winner; return to IDLE.
- Arbitration:
  - Only one requester: that master wins.
  - Both requesting: the master != last_grant wins.
  - Decision is made only in IDLE; a request arriving mid-transaction waits.
- Timing, with req first seen high in IDLE at cycle T:
  - Strobe high at T+1.
  - Write ack at T+2.
  - Read: s_rdata_i sampled at the end of cycle T+1+RD_LAT; ack and rdata_o valid at T+2+RD_LAT.
  - Next transaction earliest at IDLE T+3 (write) or T+3+RD_LAT (read).
- Master contract: req, we, addr and wdata stay stable until ack; req must be low in the cycle after ack unless a new transaction is intended.
- Strobes are mutually exclusive and never high outside ISSUE.
- s_addr_o and s_data_o hold their last value when idle.
- rdata_o of each master holds its last read value. A write ack leaves rdata_o unchanged, and the non-granted master's outputs never change.
- Only the granted master's ack can pulse; both acks are never high together.

Test Plan:
- Reset, then m0 write addr=0x304 data=0xA5A5_0001 -> s_wr_ce_o high 1 cycle at T+1 with s_addr_o=0x304 and s_data_o=0xA5A5_0001; m0_ack_o high at T+2; m1 outputs remain 0.
- m1 read addr=0x1000, RD_LAT=2, slave returns 0xDEAD_BEEF during cycle T+3 -> s_rd_ce_o high at T+1; m1_ack_o high at T+4 with m1_rdata_o=0xDEAD_BEEF.
- m0 and m1 both request continuously for 4 writes each -> grant order m0,m1,m0,m1,...; no master served twice in a row; acks never overlap.
- m1 requests while m0's read is in WAIT -> m1 is granted in the IDLE cycle after m0's ack; its strobe occurs exactly 2 cycles after m0_ack_o.
- bus2ip_rst_n asserted during WAIT of a read -> no ack; all outputs 0; after release, the first tied request goes to m0.
- Re-run with RD_LAT=1 and RD_LAT=15 -> read ack occurs at T+3 and T+17 respectively; data is captured on the correct cycle (slave data changes one cycle later are not observed).

Source files
------------

// File: rtl/ptp_bus_arb_if.sv
// Per-master request/response port for the bus2ip arbiter.
interface ptp_bus_arb_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  // Requesting master drives the command and receives ack/rdata.
  modport master (output req, we, addr, wdata, input ack, rdata);
  // Arbiter side accepts the command and returns ack/rdata.
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ptp_bus_arb.sv
// Two-master round-robin arbiter/sequencer for the PTP NIC bus2ip slave port.
module ptp_bus_arb #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic          bus2ip_clk,
  input  logic          bus2ip_rst_n,
  ptp_bus_arb_if.slave  m0,
  ptp_bus_arb_if.slave  m1,
  output logic [31:0]   s_addr_o,
  output logic [31:0]   s_data_o,
  output logic          s_rd_ce_o,
  output logic          s_wr_ce_o,
  input  logic [31:0]   s_rdata_i,
  output logic          busy_o,
  output logic          grant_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_addr, w_addr;
  logic [DW-1:0]    r_data, w_data;
  logic             r_we, w_we;
  logic             r_grant, w_grant;
  logic             r_last_grant, w_last_grant;
  logic             r_rd_ce, w_rd_ce;
  logic             r_wr_ce, w_wr_ce;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_m0_ack, w_m0_ack;
  logic             r_m1_ack, w_m1_ack;
  logic [DW-1:0]    r_m0_rdata, w_m0_rdata;
  logic [DW-1:0]    r_m1_rdata, w_m1_rdata;
  logic             r_busy, w_busy;
  logic             w_any_req;
  logic             w_pick_m1;

  // Winner selection: a lone requester wins; on a tie the master that did not go last wins.
  assign w_any_req = m0.req | m1.req;
  assign w_pick_m1 = m1.req & (~m0.req | ~r_last_grant);

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd_ce      <= 1'b0;
      r_wr_ce      <= 1'b0;
      r_cnt        <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_we         <= w_we;
      r_grant      <= w_grant;
      r_last_grant <= w_last_grant;
      r_rd_ce      <= w_rd_ce;
      r_wr_ce      <= w_wr_ce;
      r_cnt        <= w_cnt;
      r_m0_ack     <= w_m0_ack;
      r_m1_ack     <= w_m1_ack;
      r_m0_rdata   <= w_m0_rdata;
      r_m1_rdata   <= w_m1_rdata;
      r_busy       <= w_busy;
    end
  end

  // Next-state sequencing: issue strobe, optional read wait, capture, ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (r_we)             w_state_nxt = S_ACK;
        else if (RD_LAT == 1) w_state_nxt = S_CAPT;
        else                  w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (r_cnt <= CNT_W'(1)) w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and acks are single-cycle pulses.
  always_comb begin
    w_addr       = r_addr;
    w_data       = r_data;
    w_we         = r_we;
    w_grant      = r_grant;
    w_last_grant = r_last_grant;
    w_rd_ce      = 1'b0;
    w_wr_ce      = 1'b0;
    w_cnt        = r_cnt;
    w_m0_ack     = 1'b0;
    w_m1_ack     = 1'b0;
    w_m0_rdata   = r_m0_rdata;
    w_m1_rdata   = r_m1_rdata;
    w_busy       = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant = w_pick_m1;
          w_addr  = w_pick_m1 ? m1.addr  : m0.addr;
          w_data  = w_pick_m1 ? m1.wdata : m0.wdata;
          w_we    = w_pick_m1 ? m1.we    : m0.we;
          w_wr_ce = w_we;
          w_rd_ce = ~w_we;
        end
      end
      S_ISSUE: begin
        w_cnt = CNT_W'(RD_LAT - 1);
        if (r_we) begin
          w_m0_ack = ~r_grant;
          w_m1_ack = r_grant;
        end
      end
      S_WAIT: begin
        w_cnt = r_cnt - CNT_W'(1);
      end
      S_CAPT: begin
        if (r_grant) w_m1_rdata = s_rdata_i;
        else         w_m0_rdata = s_rdata_i;
        w_m0_ack = ~r_grant;
        w_m1_ack = r_grant;
      end
      S_ACK: begin
        w_last_grant = r_grant;
      end
      default: ;
    endcase
  end

  assign s_addr_o  = r_addr;
  assign s_data_o  = r_data;
  assign s_rd_ce_o = r_rd_ce;
  assign s_wr_ce_o = r_wr_ce;
  assign busy_o    = r_busy;
  assign grant_o   = r_grant;
  assign m0.ack    = r_m0_ack;
  assign m0.rdata  = r_m0_rdata;
  assign m1.ack    = r_m1_ack;
  assign m1.rdata  = r_m1_rdata;

endmodule

// File: tb/tb_ptp_bus_arb.sv
// Directed self-checking bench for ptp_bus_arb (RD_LAT = 2, 1 and 15).
module tb_ptp_bus_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_rdata;
  int          n_cmp;
  int          n_err;

  ptp_bus_arb_if m0_a ();
  ptp_bus_arb_if m1_a ();
  ptp_bus_arb_if m0_b ();
  ptp_bus_arb_if m1_b ();
  ptp_bus_arb_if m0_c ();
  ptp_bus_arb_if m1_c ();

  logic [31:0] s_addr_a, s_data_a, s_addr_b, s_data_b, s_addr_c, s_data_c;
  logic        rd_ce_a, wr_ce_a, busy_a, grant_a;
  logic        rd_ce_b, wr_ce_b, busy_b, grant_b;
  logic        rd_ce_c, wr_ce_c, busy_c, grant_c;

  ptp_bus_arb #(.RD_LAT(2)) u_dut (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n), .m0(m0_a), .m1(m1_a),
    .s_addr_o(s_addr_a), .s_data_o(s_data_a), .s_rd_ce_o(rd_ce_a), .s_wr_ce_o(wr_ce_a),
    .s_rdata_i(s_rdata), .busy_o(busy_a), .grant_o(grant_a));

  ptp_bus_arb #(.RD_LAT(1)) u_dut_lat1 (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n), .m0(m0_b), .m1(m1_b),
    .s_addr_o(s_addr_b), .s_data_o(s_data_b), .s_rd_ce_o(rd_ce_b), .s_wr_ce_o(wr_ce_b),
    .s_rdata_i(s_rdata), .busy_o(busy_b), .grant_o(grant_b));

  ptp_bus_arb #(.RD_LAT(15)) u_dut_lat15 (
    .bus2ip_clk(clk), .bus2ip_rst_n(rst_n), .m0(m0_c), .m1(m1_c),
    .s_addr_o(s_addr_c), .s_data_o(s_data_c), .s_rd_ce_o(rd_ce_c), .s_wr_ce_o(wr_ce_c),
    .s_rdata_i(s_rdata), .busy_o(busy_c), .grant_o(grant_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single read on one of the latency-variant instances, data valid only in the capture cycle.
  task automatic run_lat(input int lat, input logic [31:0] v);
    logic ack;
    logic [31:0] rd;
    if (lat == 1) begin
      m0_b.we = 1'b0; m0_b.addr = 32'h0000_1008; m0_b.req = 1'b1;
    end else begin
      m0_c.we = 1'b0; m0_c.addr = 32'h0000_1008; m0_c.req = 1'b1;
    end
    for (int k = 1; k <= lat + 3; k++) begin
      tick();
      s_rdata = (k == lat + 1) ? v : (32'hBAD0_0000 | 32'(k));
      ack = (lat == 1) ? m0_b.ack   : m0_c.ack;
      rd  = (lat == 1) ? m0_b.rdata : m0_c.rdata;
      check_eq($sformatf("lat%0d_ack_T+%0d", lat, k), 32'(ack), 32'(k == lat + 2));
      if (k >= lat + 2) begin
        check_eq($sformatf("lat%0d_rdata_T+%0d", lat, k), rd, v);
        if (lat == 1) m0_b.req = 1'b0;
        else          m0_c.req = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt0;
    int cnt1;
    logic found;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_rdata = '0;
    m0_a.req = 0; m0_a.we = 0; m0_a.addr = '0; m0_a.wdata = '0;
    m1_a.req = 0; m1_a.we = 0; m1_a.addr = '0; m1_a.wdata = '0;
    m0_b.req = 0; m0_b.we = 0; m0_b.addr = '0; m0_b.wdata = '0;
    m1_b.req = 0; m1_b.we = 0; m1_b.addr = '0; m1_b.wdata = '0;
    m0_c.req = 0; m0_c.we = 0; m0_c.addr = '0; m0_c.wdata = '0;
    m1_c.req = 0; m1_c.we = 0; m1_c.addr = '0; m1_c.wdata = '0;
    tick(); tick();

    // Reset values
    check_eq("rst_strobes", {30'd0, rd_ce_a, wr_ce_a}, 32'd0);
    check_eq("rst_busy_grant", {30'd0, busy_a, grant_a}, 32'd0);
    check_eq("rst_addr", s_addr_a, 32'd0);
    check_eq("rst_data", s_data_a, 32'd0);
    check_eq("rst_acks", {30'd0, m0_a.ack, m1_a.ack}, 32'd0);
    rst_n = 1'b1;
    tick();

    // m0 write 0x304
    m0_a.we = 1'b1; m0_a.addr = 32'h0000_0304; m0_a.wdata = 32'hA5A5_0001; m0_a.req = 1'b1;
    tick();
    check_eq("wr_ce_T+1", {30'd0, rd_ce_a, wr_ce_a}, 32'd1);
    check_eq("wr_addr", s_addr_a, 32'h0000_0304);
    check_eq("wr_data", s_data_a, 32'hA5A5_0001);
    check_eq("wr_grant_busy", {30'd0, busy_a, grant_a}, 32'd2);
    check_eq("wr_ack_T+1", 32'(m0_a.ack), 32'd0);
    tick();
    check_eq("wr_ce_T+2", {30'd0, rd_ce_a, wr_ce_a}, 32'd0);
    check_eq("wr_ack_T+2", {30'd0, m0_a.ack, m1_a.ack}, 32'd2);
    check_eq("wr_m1_rdata", m1_a.rdata, 32'd0);
    m0_a.req = 1'b0;
    tick();
    check_eq("wr_idle_T+3", {30'd0, busy_a, m0_a.ack}, 32'd0);
    check_eq("wr_addr_hold", s_addr_a, 32'h0000_0304);

    // m1 read 0x1000 with slave data valid only in T+3
    m1_a.we = 1'b0; m1_a.addr = 32'h0000_1000; m1_a.req = 1'b1;
    tick();
    s_rdata = 32'h1111_1111;
    check_eq("rd_ce_T+1", {30'd0, rd_ce_a, wr_ce_a}, 32'd2);
    check_eq("rd_addr", s_addr_a, 32'h0000_1000);
    check_eq("rd_grant", 32'(grant_a), 32'd1);
    tick();
    check_eq("rd_ce_T+2", {30'd0, rd_ce_a, wr_ce_a}, 32'd0);
    tick();
    s_rdata = 32'hDEAD_BEEF;
    check_eq("rd_ack_T+3", 32'(m1_a.ack), 32'd0);
    tick();
    s_rdata = 32'h2222_2222;
    check_eq("rd_ack_T+4", {30'd0, m0_a.ack, m1_a.ack}, 32'd1);
    check_eq("rd_m1_rdata", m1_a.rdata, 32'hDEAD_BEEF);
    check_eq("rd_m0_rdata", m0_a.rdata, 32'd0);
    m1_a.req = 1'b0;
    tick();
    check_eq("rd_ack_T+5", 32'(m1_a.ack), 32'd0);
    check_eq("rd_rdata_hold", m1_a.rdata, 32'hDEAD_BEEF);

    // Both masters stream 4 writes each: strict alternation starting with m0
    cnt0 = 4; cnt1 = 4; k = 0;
    m0_a.we = 1'b1; m0_a.addr = 32'h0000_0300; m0_a.wdata = 32'h0000_0A00; m0_a.req = 1'b1;
    m1_a.we = 1'b1; m1_a.addr = 32'h0000_2000; m1_a.wdata = 32'h0000_0B00; m1_a.req = 1'b1;
    for (int c = 0; c < 100 && k < 8; c++) begin
      tick();
      if (m0_a.ack || m1_a.ack) begin
        check_eq($sformatf("rr_ack_overlap_%0d", k), {30'd0, m0_a.ack, m1_a.ack} & 32'd3,
                 (k % 2 == 0) ? 32'd2 : 32'd1);
        if (m0_a.ack) begin
          cnt0--;
          m0_a.addr = m0_a.addr + 32'd4;
          if (cnt0 == 0) m0_a.req = 1'b0;
        end
        if (m1_a.ack) begin
          cnt1--;
          m1_a.addr = m1_a.addr + 32'd4;
          if (cnt1 == 0) m1_a.req = 1'b0;
        end
        k++;
      end
    end
    check_eq("rr_count", 32'(k), 32'd8);
    tick();

    // m1 arrives while m0's read is waiting; m1 strobe 2 cycles after m0 ack
    m0_a.we = 1'b0; m0_a.addr = 32'h0000_1004; m0_a.req = 1'b1;
    tick();
    tick();
    m1_a.we = 1'b1; m1_a.addr = 32'h0000_2010; m1_a.wdata = 32'h5555_AAAA; m1_a.req = 1'b1;
    tick();
    check_eq("mid_no_ack_T+3", {30'd0, m0_a.ack, m1_a.ack}, 32'd0);
    tick();
    check_eq("mid_m0_ack_T+4", {30'd0, m0_a.ack, m1_a.ack}, 32'd2);
    check_eq("mid_m0_rdata", m0_a.rdata, 32'h2222_2222);
    m0_a.req = 1'b0;
    tick();
    check_eq("mid_idle_no_ce", {30'd0, rd_ce_a, wr_ce_a}, 32'd0);
    tick();
    check_eq("mid_m1_wr_ce", {30'd0, rd_ce_a, wr_ce_a}, 32'd1);
    check_eq("mid_m1_grant", 32'(grant_a), 32'd1);
    check_eq("mid_m1_addr", s_addr_a, 32'h0000_2010);
    tick();
    check_eq("mid_m1_ack", {30'd0, m0_a.ack, m1_a.ack}, 32'd1);
    check_eq("mid_m0_rdata_hold", m0_a.rdata, 32'h2222_2222);
    m1_a.req = 1'b0;
    tick();

    // Reset during WAIT aborts the read; first tie afterwards goes to m0
    m0_a.we = 1'b0; m0_a.addr = 32'h0000_1010; m0_a.req = 1'b1;
    tick();
    tick();
    check_eq("ab_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("ab_outputs", {26'd0, rd_ce_a, wr_ce_a, busy_a, grant_a, m0_a.ack, m1_a.ack}, 32'd0);
    check_eq("ab_rdata", m0_a.rdata | m1_a.rdata, 32'd0);
    check_eq("ab_addr", s_addr_a, 32'd0);
    m1_a.we = 1'b1; m1_a.addr = 32'h0000_2020; m1_a.wdata = 32'h0000_0077; m1_a.req = 1'b1;
    tick();
    check_eq("ab_held_ack", {30'd0, m0_a.ack, m1_a.ack}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("ab_tie_grant_m0", 32'(grant_a), 32'd0);
    check_eq("ab_tie_rd_ce", {30'd0, rd_ce_a, wr_ce_a}, 32'd2);
    tick();
    tick();
    tick();
    check_eq("ab_m0_ack", {30'd0, m0_a.ack, m1_a.ack}, 32'd2);
    m0_a.req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (m1_a.ack) found = 1'b1;
    end
    check_eq("ab_m1_served", 32'(found), 32'd1);
    m1_a.req = 1'b0;
    tick();

    // Read latency extremes
    run_lat(1, 32'hCAFE_0001);
    tick();
    run_lat(15, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
